// File: rtl/dlx_mem_pkg.sv
// Shared types for the DLX data-RAM responder: the stored word type, the
// access FSM state encoding and the byte-per-word constant.
package dlx_mem_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    READY = 2'd2
  } state_t;

  localparam int WORD_BYTES = 4;
  localparam int BYTE_BITS  = $clog2(WORD_BYTES);

endpackage

// File: rtl/dlx_dmem_array.sv
// DEPTH x 32-bit word storage for dlx_dmem: one synchronous write port and
// one combinational read port.
module dlx_dmem_array
  import dlx_mem_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  word_t         wdata_i,
  input  logic [AW-1:0] raddr_i,
  output word_t         rdata_o
);

  word_t mem_q [DEPTH];

  // NOTE: storage is deliberately left out of reset so it maps onto RAM and
  // keeps its contents across a core reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/dlx_dmem.sv
// DLX data-RAM responder: latches the core's address, commits writes on the
// first edge of an access and raises d_data_valid after LATENCY-1 more edges.
// Optional DLX_DMEM_ERR_EN adds d_error for misaligned/out-of-range accesses.
module dlx_dmem
  import dlx_mem_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] d_address,
  input  logic [31:0] d_data_write,
  input  logic        d_write_enable,
  output logic [31:0] d_data_read,
  output logic        d_data_valid
`ifdef DLX_DMEM_ERR_EN
  ,
  output logic        d_error
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  if (LATENCY < 1) begin : g_bad_latency
    $error("dlx_dmem: LATENCY must be at least 1");
  end
  if (DEPTH != (1 << AW)) begin : g_bad_depth
    $error("dlx_dmem: DEPTH must be a power of two");
  end

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   addr_q, addr_d;
  word_t         rdata_q, rdata_d;
  logic          valid_q, valid_d;

  logic [AW-1:0] word_idx;
  logic          in_range;
  logic          new_access;
  logic          mem_we;
  word_t         mem_rdata;
  word_t         read_word;

  assign word_idx   = d_address[AW+BYTE_BITS-1:BYTE_BITS];
  assign in_range   = (d_address[31:AW+BYTE_BITS] == '0);
  assign new_access = (state_q == IDLE) || (d_address != addr_q) || d_write_enable;

`ifdef DLX_DMEM_ERR_EN
  logic misaligned;
  logic err_q, err_d;

  assign misaligned = |d_address[BYTE_BITS-1:0];
  assign mem_we     = d_write_enable && in_range && !misaligned && !reset;
`else
  assign mem_we     = d_write_enable && in_range && !reset;
`endif

  dlx_dmem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (word_idx),
    .wdata_i (d_data_write),
    .raddr_i (word_idx),
    .rdata_o (mem_rdata)
  );

  // With LATENCY==1 the write and the acknowledge share an edge, so the
  // freshly written word is forwarded around the array.
  always_comb begin
    read_word = '0;
    if (in_range) begin
      read_word = mem_we ? d_data_write : mem_rdata;
    end
  end

  // NOTE: every next-state variable takes its held value first so no path
  // through the case leaves one unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    rdata_d = rdata_q;
    valid_d = valid_q;
`ifdef DLX_DMEM_ERR_EN
    err_d   = err_q;
`endif

    if (new_access) begin
      addr_d = d_address;
`ifdef DLX_DMEM_ERR_EN
      err_d  = misaligned || !in_range;
`endif
      if (LATENCY == 1) begin
        state_d = READY;
        valid_d = 1'b1;
        rdata_d = read_word;
      end else begin
        state_d = WAIT;
        cnt_d   = CW'(LATENCY - 1);
        valid_d = 1'b0;
      end
    end else begin
      unique case (state_q)
        WAIT: begin
          if (cnt_q == CW'(1)) begin
            state_d = READY;
            valid_d = 1'b1;
            rdata_d = read_word;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        READY: rdata_d = read_word;
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      rdata_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rdata_q <= rdata_d;
      valid_q <= valid_d;
    end
  end

`ifdef DLX_DMEM_ERR_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign d_error = err_q;
`endif

  assign d_data_read  = rdata_q;
  assign d_data_valid = valid_q;

endmodule

// File: tb/tb_dlx_dmem.sv
// Directed bench for dlx_dmem: five instances (LATENCY 1..5) share one set of
// inputs; each scenario checks the instances whose latency it exercises.
module tb_dlx_dmem;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] d_address;
  logic [31:0] d_data_write;
  logic        d_write_enable;
  logic [31:0] rd [5];
  logic        v  [5];
`ifdef DLX_DMEM_ERR_EN
  logic        err [5];
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dlx_dmem #(.DEPTH(1024), .LATENCY(1)) u_l1 (
    .clk(clk), .reset(reset), .d_address(d_address), .d_data_write(d_data_write),
    .d_write_enable(d_write_enable), .d_data_read(rd[0]), .d_data_valid(v[0])
`ifdef DLX_DMEM_ERR_EN
    , .d_error(err[0])
`endif
  );
  dlx_dmem #(.DEPTH(1024), .LATENCY(2)) u_l2 (
    .clk(clk), .reset(reset), .d_address(d_address), .d_data_write(d_data_write),
    .d_write_enable(d_write_enable), .d_data_read(rd[1]), .d_data_valid(v[1])
`ifdef DLX_DMEM_ERR_EN
    , .d_error(err[1])
`endif
  );
  dlx_dmem #(.DEPTH(1024), .LATENCY(3)) u_l3 (
    .clk(clk), .reset(reset), .d_address(d_address), .d_data_write(d_data_write),
    .d_write_enable(d_write_enable), .d_data_read(rd[2]), .d_data_valid(v[2])
`ifdef DLX_DMEM_ERR_EN
    , .d_error(err[2])
`endif
  );
  dlx_dmem #(.DEPTH(1024), .LATENCY(4)) u_l4 (
    .clk(clk), .reset(reset), .d_address(d_address), .d_data_write(d_data_write),
    .d_write_enable(d_write_enable), .d_data_read(rd[3]), .d_data_valid(v[3])
`ifdef DLX_DMEM_ERR_EN
    , .d_error(err[3])
`endif
  );
  dlx_dmem #(.DEPTH(1024), .LATENCY(5)) u_l5 (
    .clk(clk), .reset(reset), .d_address(d_address), .d_data_write(d_data_write),
    .d_write_enable(d_write_enable), .d_data_read(rd[4]), .d_data_valid(v[4])
`ifdef DLX_DMEM_ERR_EN
    , .d_error(err[4])
`endif
  );

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse a one-cycle write, then idle long enough for every latency to settle.
  task automatic write_word(input logic [31:0] addr, input logic [31:0] data);
    d_address      = addr;
    d_data_write   = data;
    d_write_enable = 1'b1;
    tick();
    d_write_enable = 1'b0;
    d_data_write   = 32'hFFFF_FFFF;
    repeat (6) tick();
  endtask

  task automatic test_reset();
    write_word(32'h10, 32'hDEAD_BEEF);
    reset     = 1'b1;
    d_address = 32'h10;
    repeat (2) tick();
    checks++;
    if (v[1] !== 1'b0 || rd[1] !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: valid=%b data=%h expected valid=0 data=00000000", v[1], rd[1]);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (v[1] !== 1'b0) begin
      errors++;
      $display("FAIL first_edge_l2: valid=%b expected 0", v[1]);
    end
    checks++;
    if (v[0] !== 1'b1 || rd[0] !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL first_edge_l1: valid=%b data=%h expected 1 deadbeef", v[0], rd[0]);
    end
    tick();
    checks++;
    if (v[1] !== 1'b1 || rd[1] !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL first_read_l2: valid=%b data=%h expected 1 deadbeef", v[1], rd[1]);
    end
  endtask

  task automatic test_write_readback();
    d_address      = 32'h40;
    d_data_write   = 32'h1234_5678;
    d_write_enable = 1'b1;
    tick();
    d_write_enable = 1'b0;
    d_data_write   = 32'h0BAD_0BAD;
    checks++;
    if (v[1] !== 1'b0) begin
      errors++;
      $display("FAIL write_edge0_l2: valid=%b expected 0", v[1]);
    end
    checks++;
    if (v[0] !== 1'b1 || rd[0] !== 32'h1234_5678) begin
      errors++;
      $display("FAIL write_raw_l1: valid=%b data=%h expected 1 12345678", v[0], rd[0]);
    end
    tick();
    checks++;
    if (v[1] !== 1'b1 || rd[1] !== 32'h1234_5678) begin
      errors++;
      $display("FAIL write_raw_l2: valid=%b data=%h expected 1 12345678", v[1], rd[1]);
    end
    d_address = 32'h0;
    repeat (2) tick();
    d_address = 32'h43;
    repeat (2) tick();
    checks++;
    if (v[1] !== 1'b1 || rd[1] !== 32'h1234_5678) begin
      errors++;
      $display("FAIL readback_0x43: valid=%b data=%h expected 1 12345678", v[1], rd[1]);
    end
  endtask

  task automatic test_write_in_ready();
    d_address = 32'h40;
    repeat (3) tick();
    d_data_write   = 32'h55AA_55AA;
    d_write_enable = 1'b1;
    tick();
    d_write_enable = 1'b0;
    checks++;
    if (v[1] !== 1'b0) begin
      errors++;
      $display("FAIL ready_write_drop: valid=%b expected 0", v[1]);
    end
    tick();
    checks++;
    if (v[1] !== 1'b1 || rd[1] !== 32'h55AA_55AA) begin
      errors++;
      $display("FAIL ready_write_ack: valid=%b data=%h expected 1 55aa55aa", v[1], rd[1]);
    end
  endtask

  task automatic test_latency_sweep();
    int lats [3] = '{1, 3, 5};
    write_word(32'h80, 32'hCAFE_F00D);
    d_address = 32'h84;
    repeat (6) tick();
    d_address = 32'h80;
    for (int k = 0; k < 6; k++) begin
      tick();
      foreach (lats[j]) begin
        logic exp_v;
        exp_v = (k >= lats[j] - 1);
        checks++;
        if (v[lats[j]-1] !== exp_v || (exp_v && rd[lats[j]-1] !== 32'hCAFE_F00D)) begin
          errors++;
          $display("FAIL sweep_lat%0d_edge%0d: valid=%b data=%h expected valid=%b data=cafef00d",
                   lats[j], k, v[lats[j]-1], rd[lats[j]-1], exp_v);
        end
      end
    end
  endtask

  task automatic test_abort();
    write_word(32'h20, 32'h1111_1111);
    write_word(32'h24, 32'h9999_9999);
    d_address = 32'h0;
    repeat (6) tick();
    d_address = 32'h20;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if (v[3] !== 1'b0) begin
        errors++;
        $display("FAIL abort_old_edge%0d: valid=%b expected 0", k, v[3]);
      end
    end
    d_address = 32'h24;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (v[3] !== (k == 3) || (k == 3 && rd[3] !== 32'h9999_9999)) begin
        errors++;
        $display("FAIL abort_new_edge%0d: valid=%b data=%h expected valid=%b data=99999999",
                 k, v[3], rd[3], (k == 3));
      end
    end
  endtask

  task automatic test_out_of_range();
    write_word(32'h0, 32'h0BAD_C0DE);
    write_word(32'h1000, 32'hAAAA_5555);
    checks++;
    if (v[1] !== 1'b1 || rd[1] !== 32'h0) begin
      errors++;
      $display("FAIL oor_ack: valid=%b data=%h expected 1 00000000", v[1], rd[1]);
    end
`ifdef DLX_DMEM_ERR_EN
    checks++;
    if (err[1] !== 1'b1) begin
      errors++;
      $display("FAIL oor_error: d_error=%b expected 1", err[1]);
    end
`endif
    d_address = 32'h0;
    repeat (6) tick();
    checks++;
    if (v[1] !== 1'b1 || rd[1] !== 32'h0BAD_C0DE) begin
      errors++;
      $display("FAIL oor_no_alias: valid=%b data=%h expected 1 0badc0de", v[1], rd[1]);
    end
`ifdef DLX_DMEM_ERR_EN
    checks++;
    if (err[1] !== 1'b0) begin
      errors++;
      $display("FAIL inrange_error: d_error=%b expected 0", err[1]);
    end
`endif
  endtask

  task automatic test_reset_mid_write();
    write_word(32'h8, 32'h2222_2222);
    d_address = 32'h4;
    repeat (6) tick();
    d_address      = 32'h8;
    d_data_write   = 32'h3333_3333;
    d_write_enable = 1'b1;
    reset          = 1'b1;
    tick();
    d_write_enable = 1'b0;
    reset          = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (v[i] !== 1'b0 || rd[i] !== 32'h0) begin
        errors++;
        $display("FAIL rst_write_lat%0d: valid=%b data=%h expected 0 00000000", i + 1, v[i], rd[i]);
      end
    end
    tick();
    checks++;
    if (v[0] !== 1'b1 || rd[0] !== 32'h2222_2222) begin
      errors++;
      $display("FAIL rst_write_mem_l1: valid=%b data=%h expected 1 22222222", v[0], rd[0]);
    end
    tick();
    checks++;
    if (v[1] !== 1'b1 || rd[1] !== 32'h2222_2222) begin
      errors++;
      $display("FAIL rst_write_mem_l2: valid=%b data=%h expected 1 22222222", v[1], rd[1]);
    end
  endtask

  initial begin
    reset          = 1'b1;
    d_address      = 32'h0;
    d_data_write   = 32'h0;
    d_write_enable = 1'b0;
    repeat (2) tick();
    reset = 1'b0;

    test_reset();
    test_write_readback();
    test_write_in_ready();
    test_latency_sweep();
    test_abort();
    test_out_of_range();
    test_reset_mid_write();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
